present_uut_sequencer: RTL and testbench

- Controller that drives one PRESENT cipher UUT through a complete round-trip test vector: reset, key schedule, encrypt, reset, key schedule, decrypt, compare.
- Sits between the autotest FSM (plaintext/key in, results out) and the UUT control/data pins.
- Replaces ad-hoc UUT sequencing with a start/done handshake, per-phase timeout and pass/fail verdict.

---
 rtl/present_seq_pkg.sv | 25 ++
 rtl/present_uut_sequencer_phase_timer.sv | 34 +++
 rtl/present_uut_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_present_uut_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_seq_pkg.sv
// Shared types and constants for the PRESENT UUT round-trip sequencer.
// Holds the sequencer state encoding, timed-out phase codes and default widths.
// No logic; imported by the sequencer top and its phase timer.
package present_seq_pkg;

  localparam int DEF_BLOCK_SIZE = 64;
  localparam int DEF_KEY_SIZE   = 80;

  typedef enum logic [2:0] {
    IDLE,
    RST_ENC,
    KEY_ENC,
    ENC,
    RST_DEC,
    KEY_DEC,
    DEC,
    FINISH
  } seq_state_t;

  // Phase reported on err_phase when a wait state times out
  localparam logic [1:0] PH_KEY = 2'd0;
  localparam logic [1:0] PH_ENC = 2'd1;
  localparam logic [1:0] PH_DEC = 2'd2;

endpackage

// File: rtl/present_uut_sequencer_phase_timer.sv
// Phase timer: saturating cycle counter with a runtime terminal-count limit.
// Latency: count is 0 in the cycle after clear, tc is combinational on count.
// No backpressure; enable simply freezes the count.
module phase_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  logic [CW-1:0] count;

  // Count up while enabled, restart on clear, stick at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CW{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count: the current phase has used its allotted cycles
  always_comb begin
    tc = (count == limit);
  end

endmodule

// File: rtl/present_uut_sequencer.sv
// Drives one PRESENT UUT through reset/key/encrypt/reset/key/decrypt and checks the round trip.
// Latency: 2*RST_HOLD_CYCLES+5 cycles start->done with immediate UUT; each wait phase bounded by TIMEOUT_CYCLES.
// start is ignored while busy; PRESENT_SEQ_CYCLE_COUNT_EN adds enc_cycles/dec_cycles counters.
module present_uut_sequencer
  import present_seq_pkg::*;
#(
  parameter int BLOCK_SIZE      = DEF_BLOCK_SIZE,
  parameter int KEY_INPUT_SIZE  = DEF_KEY_SIZE,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BLOCK_SIZE-1:0]     plaintext_i,
  input  logic [KEY_INPUT_SIZE-1:0] key_i,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout_err,
  output logic [1:0]                err_phase,
  output logic [BLOCK_SIZE-1:0]     ciphertext_o,
  output logic [BLOCK_SIZE-1:0]     decrypted_o,
`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
  output logic [15:0]               enc_cycles,
  output logic [15:0]               dec_cycles,
`endif
  output logic                      rst_uut,
  output logic [BLOCK_SIZE-1:0]     block_i_uut,
  output logic [KEY_INPUT_SIZE-1:0] key_uut,
  output logic                      endec_uut,
  input  logic [BLOCK_SIZE-1:0]     block_o_uut,
  input  logic                      end_key_signal_uut,
  input  logic                      end_enc_uut,
  input  logic                      end_dec_uut
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t state, next_state;

  logic [BLOCK_SIZE-1:0] pt_lat;
  logic                  start_ok;
  logic                  to_hit;
  logic [1:0]            to_phase;
  logic                  tmr_clear;
  logic                  tmr_en;
  logic [CW-1:0]         tmr_limit;
  logic                  tmr_tc;

  assign start_ok = (state == IDLE) && start;

  // One timer serves both the reset hold and the wait-phase timeout;
  // it restarts on every state change so each phase counts from zero.
  assign tmr_clear = (next_state != state);
  assign tmr_en    = (state != IDLE);
  assign tmr_limit = ((state == RST_ENC) || (state == RST_DEC)) ? HOLD_LIM : TO_LIM;

  phase_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .tc     (tmr_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and timeout detection; completion wins over a coincident timeout
  always_comb begin
    next_state = state;
    to_hit     = 1'b0;
    to_phase   = PH_KEY;
    unique case (state)
      IDLE:    if (start) next_state = RST_ENC;
      RST_ENC: if (tmr_tc) next_state = KEY_ENC;
      KEY_ENC: begin
        if (end_key_signal_uut) next_state = ENC;
        else if (tmr_tc) begin
          next_state = FINISH;
          to_hit     = 1'b1;
          to_phase   = PH_KEY;
        end
      end
      ENC: begin
        if (end_enc_uut) next_state = RST_DEC;
        else if (tmr_tc) begin
          next_state = FINISH;
          to_hit     = 1'b1;
          to_phase   = PH_ENC;
        end
      end
      RST_DEC: if (tmr_tc) next_state = KEY_DEC;
      KEY_DEC: begin
        if (end_key_signal_uut) next_state = DEC;
        else if (tmr_tc) begin
          next_state = FINISH;
          to_hit     = 1'b1;
          to_phase   = PH_KEY;
        end
      end
      DEC: begin
        next_state = FINISH;
        if (!end_dec_uut && !tmr_tc) next_state = DEC;
        else if (!end_dec_uut) begin
          to_hit   = 1'b1;
          to_phase = PH_DEC;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // UUT control pins and handshake outputs follow the current state
  always_comb begin
    busy      = (state != IDLE) && (state != FINISH);
    done      = (state == FINISH);
    rst_uut   = (state == IDLE) || (state == RST_ENC) || (state == RST_DEC) || (state == FINISH);
    endec_uut = (state == RST_DEC) || (state == KEY_DEC) || (state == DEC);
  end

  // Latch the test vector, capture UUT results and record the verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pt_lat       <= '0;
      key_uut      <= '0;
      block_i_uut  <= '0;
      ciphertext_o <= '0;
      decrypted_o  <= '0;
      pass         <= 1'b0;
      timeout_err  <= 1'b0;
      err_phase    <= PH_KEY;
    end else begin
      if (start_ok) begin
        pt_lat      <= plaintext_i;
        key_uut     <= key_i;
        block_i_uut <= plaintext_i;
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        err_phase   <= PH_KEY;
      end
      // Ciphertext becomes the decrypt-phase block input
      if ((state == ENC) && end_enc_uut) begin
        ciphertext_o <= block_o_uut;
        block_i_uut  <= block_o_uut;
      end
      // Verdict is registered on entry to FINISH so it is valid with done
      if ((state == DEC) && end_dec_uut) begin
        decrypted_o <= block_o_uut;
        pass        <= (block_o_uut == pt_lat);
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
        err_phase   <= to_phase;
        pass        <= 1'b0;
      end
    end
  end

`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
  // Cycles spent in key schedule plus cipher run, per direction, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_cycles <= '0;
      dec_cycles <= '0;
    end else if (start_ok) begin
      enc_cycles <= '0;
      dec_cycles <= '0;
    end else begin
      if (((state == KEY_ENC) || (state == ENC)) && (enc_cycles != 16'hFFFF))
        enc_cycles <= enc_cycles + 16'd1;
      if (((state == KEY_DEC) || (state == DEC)) && (dec_cycles != 16'hFFFF))
        dec_cycles <= dec_cycles + 16'd1;
    end
  end
`else
  // Cycle counters are not built in this configuration
`endif

endmodule

// File: tb/tb_present_uut_sequencer.sv
// Bench for present_uut_sequencer with a behavioural PRESENT-80 UUT model.
// Directed vectors: known-answer round trips, corrupted decrypt, timeout, ignored start, async abort.
module tb_present_uut_sequencer;

  localparam int H  = 4;
`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
  localparam int TO = 64;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] plaintext_i;
  logic [79:0] key_i;
  logic        busy, done, pass, timeout_err;
  logic [1:0]  err_phase;
  logic [63:0] ciphertext_o, decrypted_o;
`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
  logic [15:0] enc_cycles, dec_cycles;
`endif
  logic        rst_uut;
  logic [63:0] block_i_uut;
  logic [79:0] key_uut;
  logic        endec_uut;
  logic [63:0] block_o_uut;
  logic        end_key_signal_uut, end_enc_uut, end_dec_uut;

  int n_chk = 0;
  int n_bad = 0;

  // UUT model controls
  int kl = 1;
  int el = 1;
  int dl = 1;
  bit never_enc = 0;
  bit corrupt = 0;
  int ucnt = 0;

  present_uut_sequencer #(
    .BLOCK_SIZE      (64),
    .KEY_INPUT_SIZE  (80),
    .RST_HOLD_CYCLES (H),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .plaintext_i        (plaintext_i),
    .key_i              (key_i),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .timeout_err        (timeout_err),
    .err_phase          (err_phase),
    .ciphertext_o       (ciphertext_o),
    .decrypted_o        (decrypted_o),
`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
    .enc_cycles         (enc_cycles),
    .dec_cycles         (dec_cycles),
`endif
    .rst_uut            (rst_uut),
    .block_i_uut        (block_i_uut),
    .key_uut            (key_uut),
    .endec_uut          (endec_uut),
    .block_o_uut        (block_o_uut),
    .end_key_signal_uut (end_key_signal_uut),
    .end_enc_uut        (end_enc_uut),
    .end_dec_uut        (end_dec_uut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PRESENT-80 reference model ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] y);
    logic [3:0] r;
    r = 4'h0;
    for (int v = 0; v < 16; v++) if (sb(4'(v)) == y) r = 4'(v);
    return r;
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv ? isb(s[4*n +: 4]) : sb(s[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) begin
      if (!inv) o[(i*16)%63] = s[i];
      else      o[i] = s[(i*16)%63];
    end
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] blk, input logic [79:0] key, input bit dec);
    logic [79:0] k;
    logic [63:0] rk [1:32];
    logic [63:0] s;
    k = key;
    rk[1] = k[79:16];
    for (int r = 1; r <= 31; r++) begin
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
      rk[r+1] = k[79:16];
    end
    if (!dec) begin
      s = blk;
      for (int r = 1; r <= 31; r++) s = player(slayer(s ^ rk[r], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = blk ^ rk[32];
      for (int r = 31; r >= 1; r--) s = slayer(player(s, 1'b1), 1'b1) ^ rk[r];
    end
    return s;
  endfunction

  // UUT model: combinational cipher, completion levels timed from reset release
  always @(posedge clk) begin
    if (rst_uut) ucnt <= 0;
    else if (ucnt < 100000) ucnt <= ucnt + 1;
  end

  always_comb begin
    block_o_uut = present80(block_i_uut, key_uut, endec_uut);
    if (corrupt && endec_uut) block_o_uut[0] = ~block_o_uut[0];
  end

  assign end_key_signal_uut = !rst_uut && (ucnt >= kl - 1);
  assign end_enc_uut        = !rst_uut && !never_enc && (ucnt >= kl + el - 1);
  assign end_dec_uut        = !rst_uut && (ucnt >= kl + dl - 1);

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start and wait (bounded) for done; lat counts edges from the start edge
  task automatic run_vec(input logic [63:0] p, input logic [79:0] k, output int lat);
    plaintext_i = p;
    key_i       = k;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    check_eq("busy_after_start", busy, 1);
    while (!done && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("done_seen", done, 1);
    check_eq("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
  endtask

  int lat;
  int ndone;
  int guard;

  initial begin
    rst = 1'b0; start = 1'b0; plaintext_i = '0; key_i = '0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_to", timeout_err, 0);
    check_eq("rst_errph", err_phase, 0);
    check_eq("rst_rst_uut", rst_uut, 1);
    check_eq("rst_endec", endec_uut, 0);
    check_eq("rst_ct", ciphertext_o, 0);
    check_eq("rst_key_uut", key_uut, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Vector 1: all-zero known answer
    run_vec(64'h0, 80'h0, lat);
    check_eq("v1_latency", lat, 2*H + 5);
    check_eq("v1_ct", ciphertext_o, 64'h5579C1387B228445);
    check_eq("v1_dec", decrypted_o, 64'h0);
    check_eq("v1_pass", pass, 1);
    check_eq("v1_to", timeout_err, 0);

    // Vector 2: all-ones known answer
    run_vec(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, lat);
    check_eq("v2_ct", ciphertext_o, 64'h3333DCD3213210D2);
    check_eq("v2_dec", decrypted_o, 64'hFFFFFFFFFFFFFFFF);
    check_eq("v2_pass", pass, 1);

    // Corrupted decryption: bit 0 flipped by the UUT
    corrupt = 1;
    run_vec(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, lat);
    corrupt = 0;
    check_eq("bad_dec", decrypted_o, 64'hFFFFFFFFFFFFFFFE);
    check_eq("bad_pass", pass, 0);
    check_eq("bad_to", timeout_err, 0);

    // Encrypt never completes: timeout in ENC, ciphertext keeps previous value
    never_enc = 1;
    run_vec(64'h0, 80'h0, lat);
    never_enc = 0;
    check_eq("to_latency", lat, H + 2 + TO);
    check_eq("to_flag", timeout_err, 1);
    check_eq("to_phase", err_phase, 1);
    check_eq("to_pass", pass, 0);
    check_eq("to_ct_kept", ciphertext_o, 64'h3333DCD3213210D2);

`ifdef PRESENT_SEQ_CYCLE_COUNT_EN
    // Key schedule 3 cycles, encrypt 32 cycles
    kl = 3; el = 32; dl = 1;
    run_vec(64'h0, 80'h0, lat);
    check_eq("cnt_enc", enc_cycles, 35);
    check_eq("cnt_dec", dec_cycles, 4);
    check_eq("cnt_ct", ciphertext_o, 64'h5579C1387B228445);
    kl = 1; el = 1; dl = 1;
`endif

    // Restart attempt during ENC is ignored; async reset during DEC aborts
    el = 8; dl = 8;
    plaintext_i = 64'h0; key_i = 80'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (H + 2) begin @(posedge clk); #1; end
    plaintext_i = 64'hFFFFFFFFFFFFFFFF; key_i = {80{1'b1}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ign_busy", busy, 1);
    check_eq("ign_rst_uut", rst_uut, 0);
    guard = 0;
    while (!(endec_uut && !rst_uut) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("ign_reach_dec", endec_uut && !rst_uut, 1);
    check_eq("ign_key_kept", key_uut, 80'h0);
    check_eq("ign_blk_ct", block_i_uut, 64'h5579C1387B228445);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_rst_uut", rst_uut, 1);
    check_eq("abort_endec", endec_uut, 0);
    check_eq("abort_ct", ciphertext_o, 0);
    check_eq("abort_dec", decrypted_o, 0);
    check_eq("abort_blk", block_i_uut, 0);
    check_eq("abort_key", key_uut, 0);
    check_eq("abort_flags", {pass, timeout_err, err_phase}, 4'b0000);
    #3;
    rst = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    check_eq("abort_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
